// File: rtl/mixer_mac.sv
// mixer_mac
//
// Vocoder mixer: takes one frame of carrier and envelope samples, forms the
// masked sum of per-channel products through one time-shared multiplier,
// scales the sum by an arithmetic right shift (optionally rounded half up)
// and saturates the result to OUT_W bits.
//
// Ports
//   clk_in             system clock
//   rst_n_in           asynchronous active-low reset
//   valid_in/ready_in  input frame handshake (ready_in high only when idle)
//   carrier_channels   N_CHANNELS signed carrier samples
//   envelope_channels  N_CHANNELS signed envelope samples
//   channel_mask       bit i = 1 includes channel i in the sum
//   shift_in           unsigned right-shift amount
//   round_en           1 = round half up, 0 = truncate toward -inf
//   mixed_out          scaled, saturated result
//   sat_out            mixed_out was clamped
//   valid_out/ready_out output handshake
module mixer_mac #(
  parameter int N_CHANNELS = 8,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 24,
  parameter int SHIFT_W    = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic signed [DATA_W-1:0] carrier_channels  [N_CHANNELS],
  input  logic signed [DATA_W-1:0] envelope_channels [N_CHANNELS],
  input  logic [N_CHANNELS-1:0]    channel_mask,
  input  logic [SHIFT_W-1:0]       shift_in,
  input  logic                     round_en,
  output logic signed [OUT_W-1:0]  mixed_out,
  output logic                     sat_out,
  output logic                     valid_out,
  input  logic                     ready_out
);

  localparam int IDX_W  = $clog2(N_CHANNELS);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  // One extra bit so the rounding constant can never overflow the sum.
  localparam int EXT_W  = ACC_W + 1;
  localparam int CNT_W  = $clog2(N_CHANNELS + 1);

  localparam logic signed [EXT_W-1:0] MAX_V =
    EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] MIN_V =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, SCALE, SAT, HOLD} state_t;

  state_t state_reg, state_next;

  logic signed [DATA_W-1:0] carrier_reg  [N_CHANNELS];
  logic signed [DATA_W-1:0] envelope_reg [N_CHANNELS];
  logic [N_CHANNELS-1:0]    mask_reg;
  logic [SHIFT_W-1:0]       shift_reg;
  logic                     round_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [EXT_W-1:0]  scaled_reg;

  logic                     accept;
  logic signed [DATA_W-1:0] sel_carrier;
  logic signed [DATA_W-1:0] sel_envelope;
  logic                     sel_mask;
  logic signed [PROD_W-1:0] prod_next;
  logic signed [EXT_W-1:0]  acc_ext;
  logic signed [EXT_W-1:0]  rnd_sum;
  logic signed [EXT_W-1:0]  scaled_next;
  logic                     sat_hi;
  logic                     sat_lo;

  assign ready_in = (state_reg == IDLE);
  assign accept   = ready_in && valid_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (valid_in) state_next = RUN;
      // cnt_reg == N_CHANNELS marks the cycle of the final accumulate.
      RUN:   if (cnt_reg == CNT_W'(N_CHANNELS)) state_next = SCALE;
      SCALE: state_next = SAT;
      SAT:   state_next = HOLD;
      HOLD:  if (ready_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand select for the shared multiplier.
  always_comb begin
    sel_carrier  = '0;
    sel_envelope = '0;
    sel_mask     = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        sel_carrier  = carrier_reg[i];
        sel_envelope = envelope_reg[i];
        sel_mask     = mask_reg[i];
      end
    end
    prod_next = sel_mask ? PROD_W'(sel_carrier) * PROD_W'(sel_envelope) : '0;
  end

  // Scaling: shifts at or beyond the accumulator width collapse to the sign.
  always_comb begin
    acc_ext     = EXT_W'(acc_reg);
    rnd_sum     = acc_ext;
    scaled_next = '0;
    if (32'(shift_reg) >= ACC_W) begin
      scaled_next = acc_reg[ACC_W-1] ? '1 : '0;
    end else begin
      if (round_reg && (shift_reg != '0))
        rnd_sum = acc_ext + (EXT_W'(1) << (shift_reg - SHIFT_W'(1)));
      scaled_next = rnd_sum >>> shift_reg;
    end
  end

  assign sat_hi = (scaled_reg > MAX_V);
  assign sat_lo = (scaled_reg < MIN_V);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        carrier_reg[i]  <= '0;
        envelope_reg[i] <= '0;
      end
      mask_reg   <= '0;
      shift_reg  <= '0;
      round_reg  <= 1'b0;
      cnt_reg    <= '0;
      prod_reg   <= '0;
      acc_reg    <= '0;
      scaled_reg <= '0;
      mixed_out  <= '0;
      sat_out    <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
              carrier_reg[i]  <= carrier_channels[i];
              envelope_reg[i] <= envelope_channels[i];
            end
            mask_reg  <= channel_mask;
            shift_reg <= shift_in;
            round_reg <= round_en;
            cnt_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        RUN: begin
          // Stage 1 multiplies channel cnt_reg; stage 2 adds the product
          // registered on the previous cycle.
          if (cnt_reg != CNT_W'(N_CHANNELS)) begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + CNT_W'(1);
          end
          if (cnt_reg != '0)
            acc_reg <= acc_reg + ACC_W'(prod_reg);
        end
        SCALE: scaled_reg <= scaled_next;
        SAT: begin
          if (sat_hi)      mixed_out <= MAX_V[OUT_W-1:0];
          else if (sat_lo) mixed_out <= MIN_V[OUT_W-1:0];
          else             mixed_out <= scaled_reg[OUT_W-1:0];
          sat_out   <= sat_hi | sat_lo;
          valid_out <= 1'b1;
        end
        HOLD: if (ready_out) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_mac.sv
// Directed testbench for mixer_mac with N_CHANNELS=4, DATA_W=16, OUT_W=16.
module tb_mixer_mac;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int SW = 6;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic                 valid_in;
  logic                 ready_in;
  logic signed [DW-1:0] carrier_channels  [N];
  logic signed [DW-1:0] envelope_channels [N];
  logic [N-1:0]         channel_mask;
  logic [SW-1:0]        shift_in;
  logic                 round_en;
  logic signed [OW-1:0] mixed_out;
  logic                 sat_out;
  logic                 valid_out;
  logic                 ready_out;

  int checks = 0;
  int fails  = 0;
  int lat;
  logic signed [OW-1:0] held_mixed;

  always #5 clk_in = ~clk_in;

  mixer_mac #(.N_CHANNELS(N), .DATA_W(DW), .OUT_W(OW), .SHIFT_W(SW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .carrier_channels(carrier_channels), .envelope_channels(envelope_channels),
    .channel_mask(channel_mask), .shift_in(shift_in), .round_en(round_en),
    .mixed_out(mixed_out), .sat_out(sat_out),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_frame(input int c0, c1, c2, c3, e0, e1, e2, e3,
                           input int mask, input int sh, input int rnd);
    carrier_channels[0]  = DW'(c0);
    carrier_channels[1]  = DW'(c1);
    carrier_channels[2]  = DW'(c2);
    carrier_channels[3]  = DW'(c3);
    envelope_channels[0] = DW'(e0);
    envelope_channels[1] = DW'(e1);
    envelope_channels[2] = DW'(e2);
    envelope_channels[3] = DW'(e3);
    channel_mask         = N'(mask);
    shift_in             = SW'(sh);
    round_en             = rnd[0];
  endtask

  // Offer the frame; the accept edge is the next posedge.
  task automatic accept_frame(input string tag);
    @(negedge clk_in);
    check({tag, "_ready_in"}, int'(ready_in), 1);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    // Scramble the inputs to confirm they were captured on accept.
    set_frame(7, 7, 7, 7, -3, -3, -3, -3, 'hF, 2, 1);
  endtask

  // Count edges from the accept edge until valid_out is seen.
  task automatic wait_valid(input string tag);
    lat = 0;
    while (!valid_out && lat < 30) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 7);
  endtask

  task automatic run_frame(input string tag, input int exp_mixed, input int exp_sat);
    accept_frame(tag);
    wait_valid(tag);
    check({tag, "_mixed"}, int'(mixed_out), exp_mixed);
    check({tag, "_sat"}, int'(sat_out), exp_sat);
    @(posedge clk_in);
    #1;
    check({tag, "_valid_drop"}, int'(valid_out), 0);
  endtask

  initial begin
    rst_n_in  = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset_ready_in", int'(ready_in), 1);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_mixed", int'(mixed_out), 0);
    check("reset_sat", int'(sat_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Basic
    set_frame(1, 2, 3, 4, 10, 10, 10, 10, 'hF, 0, 0);
    run_frame("basic", 100, 0);

    // Rounding
    set_frame(5, 0, 0, 0, 1, 1, 1, 1, 'hF, 1, 1);
    run_frame("rnd_p5_r1", 3, 0);
    set_frame(5, 0, 0, 0, 1, 1, 1, 1, 'hF, 1, 0);
    run_frame("rnd_p5_r0", 2, 0);
    set_frame(-5, 0, 0, 0, 1, 1, 1, 1, 'hF, 1, 1);
    run_frame("rnd_m5_r1", -2, 0);
    set_frame(-5, 0, 0, 0, 1, 1, 1, 1, 'hF, 1, 0);
    run_frame("rnd_m5_r0", -3, 0);
    set_frame(-5, 0, 0, 0, 1, 1, 1, 1, 'hF, 63, 0);
    run_frame("shift63_m5", -1, 0);
    // 10,000,000 / 1024 = 9765.625
    set_frame(1000, 2000, 3000, 4000, 1000, 1000, 1000, 1000, 'hF, 10, 0);
    run_frame("shift10_r0", 9765, 0);
    set_frame(1000, 2000, 3000, 4000, 1000, 1000, 1000, 1000, 'hF, 10, 1);
    run_frame("shift10_r1", 9766, 0);

    // Saturation
    set_frame(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 'hF, 0, 0);
    run_frame("sat_pos", 32767, 1);
    set_frame(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, 'hF, 0, 0);
    run_frame("sat_neg", -32768, 1);
    set_frame(1, 2, 3, 4, 10, 10, 10, 10, 'hF, 0, 0);
    run_frame("sat_clear", 100, 0);

    // Mask: channels 0 and 2 only
    set_frame(1, 2, 3, 4, 1, 1, 1, 1, 'b0101, 0, 0);
    run_frame("mask_0101", 4, 0);

    // Backpressure
    ready_out = 1'b0;
    set_frame(2, 2, 2, 2, 5, 5, 5, 5, 'hF, 0, 0);
    accept_frame("bp");
    wait_valid("bp");
    check("bp_mixed", int'(mixed_out), 40);
    held_mixed = mixed_out;
    set_frame(9, 9, 9, 9, 9, 9, 9, 9, 'hF, 0, 0);
    valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("bp_hold_valid", int'(valid_out), 1);
      check("bp_hold_mixed", int'(mixed_out), int'(held_mixed));
      check("bp_hold_sat", int'(sat_out), 0);
      check("bp_hold_ready_in", int'(ready_in), 0);
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk_in);
    #1;
    check("bp_release_valid", int'(valid_out), 0);
    check("bp_release_ready_in", int'(ready_in), 1);
    repeat (3) @(posedge clk_in);
    #1;
    check("bp_not_accepted", int'(ready_in), 1);
    set_frame(3, 1, 4, 1, 2, 2, 2, 2, 'hF, 0, 0);
    run_frame("bp_next", 18, 0);

    // Reset mid-frame
    set_frame(4, 4, 4, 4, 4, 4, 4, 4, 'hF, 0, 0);
    accept_frame("rst");
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_mixed", int'(mixed_out), 0);
    check("rst_ready_in", int'(ready_in), 1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("rst_release_ready", int'(ready_in), 1);
    set_frame(1, 2, 3, 4, 10, 10, 10, 10, 'hF, 0, 0);
    run_frame("rst_after", 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
